bram_debug_sequencer: RTL

Synthesizable successor to the bench-side BRAM load/run/dump flow. It drives the A2/WD2/WE2 debug ports of CHANNELS BRAMs and reads their RD2 ports. It accepts commands (LOAD, DUMP, RUN, CLEAR) and moves words over valid/ready streams. It sits between a host link (UART/JTAG bridge) and RV32Core, and controls the core's reset.

---
 rtl/bram_dbg_pkg.sv | 26 ++
 rtl/bram_dbg_chan_mux.sv | 55 +++++
 rtl/bram_debug_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bram_dbg_pkg.sv
// Shared types for the BRAM debug sequencer: command encoding,
// sequencer states and the word-size helper.
package bram_dbg_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_DUMP  = 2'b01,
        OP_RUN   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_DRD,
        S_DOUT,
        S_RST_HOLD,
        S_RUN
    } state_e;

    function automatic int bytes_per_word(input int dataW);
        return dataW / 8;
    endfunction

endpackage

// File: rtl/bram_dbg_chan_mux.sv
// Steers A2/WD2/WE2 onto the selected BRAM debug port and
// selects its RD2 into a capture register.
module bram_dbg_chan_mux
    import bram_dbg_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int CW       = 1
) (
    input  logic                     CPU_CLK,
    input  logic                     CPU_RST,
    input  logic [CW-1:0]            chan,
    input  logic                     drive,
    input  logic [ADDR_W-1:0]        a2,
    input  logic [DATA_W-1:0]        wd2,
    input  logic [DATA_W/8-1:0]      we2,
    input  logic                     capture,
    output logic [CHANNELS*ADDR_W-1:0]   dbgA2,
    output logic [CHANNELS*DATA_W-1:0]   dbgWd2,
    output logic [CHANNELS*DATA_W/8-1:0] dbgWe2,
    input  logic [CHANNELS*DATA_W-1:0]   dbgRd2,
    output logic [DATA_W-1:0]        rdData
);

    localparam int BW = DATA_W / 8;

    logic [DATA_W-1:0] rdSel;

    always_comb begin
        dbgA2  = '0;
        dbgWd2 = '0;
        dbgWe2 = '0;
        rdSel  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(chan) == c) begin
                rdSel = dbgRd2[c*DATA_W +: DATA_W];
                if (drive) begin
                    dbgA2[c*ADDR_W +: ADDR_W]  = a2;
                    dbgWd2[c*DATA_W +: DATA_W] = wd2;
                    dbgWe2[c*BW +: BW]         = we2;
                end
            end
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            rdData <= '0;
        end else if (capture) begin
            rdData <= rdSel;
        end
    end

endmodule

// File: rtl/bram_debug_sequencer.sv
// LOAD/DUMP/CLEAR/RUN sequencer for the BRAM debug ports,
// owning the RV32Core reset while it runs.
module bram_debug_sequencer
    import bram_dbg_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int WORDS      = 4096,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int READ_LAT   = 1,
    parameter int RST_CYCLES = 5,
    parameter int RUN_CYCLES = 200000,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int LW = $clog2(WORDS) + 1
) (
    input  logic                         CPU_CLK,
    input  logic                         CPU_RST,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [CW-1:0]                cmd_chan,
    input  logic [LW-1:0]                cmd_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [ADDR_W-1:0]            out_addr,
    output logic                         out_last,
    output logic [CHANNELS*ADDR_W-1:0]   dbg_a2,
    output logic [CHANNELS*DATA_W-1:0]   dbg_wd2,
    output logic [CHANNELS*DATA_W/8-1:0] dbg_we2,
    input  logic [CHANNELS*DATA_W-1:0]   dbg_rd2,
    output logic                         core_rst,
    output logic                         busy,
    output logic                         done,
    output logic                         short_load
);

    localparam int BPW = bytes_per_word(DATA_W);
    localparam int TW  = 32;

    state_e            st, stN;
    logic [CW-1:0]     chanQ, chanN;
    logic [LW-1:0]     lenQ, lenN, cnt, cntN, cntInc, effLen;
    logic [ADDR_W-1:0] addr, addrN, addrInc, outAddr, outAddrN;
    logic [TW-1:0]     tmr, tmrN;
    logic              coreRst, coreRstN, shortQ, shortN;
    logic              outLast, outLastN, doneQ, doneN;
    logic              drive, capture;
    logic [DATA_W-1:0] wd;
    logic [BPW-1:0]    we;

    assign cntInc  = cnt + LW'(1);
    assign addrInc = addr + ADDR_W'(BPW);
    // Zero or oversized lengths mean a full BRAM, so addresses never wrap.
    assign effLen  = (cmd_len == '0 || cmd_len > LW'(WORDS)) ?
                     LW'(WORDS) : cmd_len;

    always_comb begin
        stN      = st;
        chanN    = chanQ;
        lenN     = lenQ;
        cntN     = cnt;
        addrN    = addr;
        tmrN     = tmr;
        coreRstN = coreRst;
        shortN   = shortQ;
        outAddrN = outAddr;
        outLastN = outLast;
        doneN    = 1'b0;
        drive    = 1'b0;
        capture  = 1'b0;
        wd       = '0;
        we       = '0;
        unique case (st)
            S_IDLE: begin
                if (cmd_valid) begin
                    chanN    = cmd_chan;
                    lenN     = effLen;
                    cntN     = '0;
                    addrN    = '0;
                    tmrN     = '0;
                    coreRstN = 1'b1;
                    unique case (op_e'(cmd_op))
                        OP_LOAD: begin
                            stN    = S_LOAD;
                            shortN = 1'b0;
                        end
                        OP_DUMP:  stN = S_DRD;
                        OP_RUN:   stN = S_RST_HOLD;
                        OP_CLEAR: stN = S_CLEAR;
                    endcase
                end
            end
            S_LOAD: begin
                drive = 1'b1;
                if (in_valid) begin
                    we    = '1;
                    wd    = in_data;
                    addrN = addrInc;
                    cntN  = cntInc;
                    if (cntInc == lenQ || in_last) begin
                        stN   = S_IDLE;
                        doneN = 1'b1;
                        if (cntInc < lenQ) shortN = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                drive = 1'b1;
                we    = '1;
                addrN = addrInc;
                cntN  = cntInc;
                if (cntInc == lenQ) begin
                    stN   = S_IDLE;
                    doneN = 1'b1;
                end
            end
            S_DRD: begin
                drive = 1'b1;
                if (tmr == TW'(READ_LAT - 1)) begin
                    capture  = 1'b1;
                    outAddrN = addr;
                    outLastN = (cntInc == lenQ);
                    tmrN     = '0;
                    stN      = S_DOUT;
                end else begin
                    tmrN = tmr + TW'(1);
                end
            end
            S_DOUT: begin
                drive = 1'b1;
                if (out_ready) begin
                    if (outLast) begin
                        stN   = S_IDLE;
                        doneN = 1'b1;
                    end else begin
                        addrN = addrInc;
                        cntN  = cntInc;
                        stN   = S_DRD;
                    end
                end
            end
            S_RST_HOLD: begin
                if (tmr == TW'(RST_CYCLES - 1)) begin
                    tmrN     = '0;
                    coreRstN = 1'b0;
                    stN      = S_RUN;
                end else begin
                    tmrN = tmr + TW'(1);
                end
            end
            S_RUN: begin
                if (tmr == TW'(RUN_CYCLES - 1)) begin
                    stN   = S_IDLE;
                    doneN = 1'b1;
                end else begin
                    tmrN = tmr + TW'(1);
                end
            end
            default: stN = S_IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            st      <= S_IDLE;
            chanQ   <= '0;
            lenQ    <= '0;
            cnt     <= '0;
            addr    <= '0;
            tmr     <= '0;
            coreRst <= 1'b1;
            shortQ  <= 1'b0;
            outAddr <= '0;
            outLast <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            st      <= stN;
            chanQ   <= chanN;
            lenQ    <= lenN;
            cnt     <= cntN;
            addr    <= addrN;
            tmr     <= tmrN;
            coreRst <= coreRstN;
            shortQ  <= shortN;
            outAddr <= outAddrN;
            outLast <= outLastN;
            doneQ   <= doneN;
        end
    end

    bram_dbg_chan_mux #(
        .CHANNELS (CHANNELS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .CW       (CW)
    ) u_mux (
        .CPU_CLK (CPU_CLK),
        .CPU_RST (CPU_RST),
        .chan    (chanQ),
        .drive   (drive),
        .a2      (addr),
        .wd2     (wd),
        .we2     (we),
        .capture (capture),
        .dbgA2   (dbg_a2),
        .dbgWd2  (dbg_wd2),
        .dbgWe2  (dbg_we2),
        .dbgRd2  (dbg_rd2),
        .rdData  (out_data)
    );

    assign cmd_ready  = (st == S_IDLE);
    assign busy       = (st != S_IDLE);
    assign in_ready   = (st == S_LOAD);
    assign out_valid  = (st == S_DOUT);
    assign out_addr   = outAddr;
    assign out_last   = outLast && (st == S_DOUT);
    assign core_rst   = coreRst;
    assign done       = doneQ;
    assign short_load = shortQ;

endmodule
